bmf_h_decoder_seq: RTL and testbench

// Programmable, pipelined Boolean-matrix decompressor. It is the receiving end of a BMF partition:
// a K-bit latent word k (produced by a w-side compressor) is expanded into M output bits through a
// run-time-loaded K x M matrix H, replacing hard-wired h-side logic. It sits behind the compressor
// in approximate-circuit evaluation harnesses. H can be reloaded to sweep factorizations without resynthesis.

---
 rtl/bmf_h_decoder_seq.sv | 151 +++++++++++++++
 tb/tb_bmf_h_decoder_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmf_h_decoder_seq.sv
// Programmable Boolean-matrix decompressor: expands a K-bit latent word through a run-time loaded
// K x M matrix H (OR or GF(2) semiring) in a two-stage valid/ready pipeline.
module bmf_h_decoder_seq #(
    parameter int unsigned K        = 7,
    parameter int unsigned M        = 8,
    parameter int unsigned SEMIRING = 0,
    localparam int unsigned AW      = (K > 1) ? $clog2(K) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [M-1:0]  cfg_data,
    input  logic          cfg_done,
    input  logic          cfg_clear,
    output logic          cfg_err,
    output logic          running,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [K-1:0]  in_k,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [M-1:0]  out_data
);

    typedef enum logic [1:0] {
        ST_CFG   = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               state;
    logic [K-1:0][M-1:0]  h;
    logic [K-1:0][M-1:0]  pp;
    logic [K-1:0][M-1:0]  prod;
    logic [K-1:0]         rows_written;
    logic [K-1:0]         rows_nx;
    logic                 s1_valid;
    logic                 s1_load;
    logic                 s2_load;
    logic                 in_fire;
    logic                 addr_ok;
    logic                 cfg_write;
    logic [M-1:0]         reduced;

    // Handshake, config-write qualification and row tracking including a same-cycle write.
    always_comb begin
        s2_load   = !out_valid || out_ready;
        s1_load   = !s1_valid || s2_load;
        in_ready  = running && s1_load;
        in_fire   = in_valid && in_ready;
        addr_ok   = 32'(cfg_addr) < K;
        cfg_write = (state == ST_CFG) && cfg_we && addr_ok;
        rows_nx   = rows_written;
        if (cfg_write) begin
            rows_nx[cfg_addr] = 1'b1;
        end
    end

    // Partial products k[i] & H[i][j] captured by stage 1.
    always_comb begin
        prod = '0;
        for (int i = 0; i < int'(K); i++) begin
            prod[i] = in_k[i] ? h[i] : '0;
        end
    end

    // Column reduction performed in front of stage 2.
    always_comb begin
        reduced = '0;
        for (int j = 0; j < int'(M); j++) begin
            for (int i = 0; i < int'(K); i++) begin
                if (SEMIRING == 0) begin
                    reduced[j] = reduced[j] | pp[i][j];
                end else begin
                    reduced[j] = reduced[j] ^ pp[i][j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_CFG;
            h            <= '0;
            rows_written <= '0;
            cfg_err      <= 1'b0;
            running      <= 1'b0;
            s1_valid     <= 1'b0;
            pp           <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
        end else begin
            case (state)
                ST_CFG: begin
                    if (cfg_write) begin
                        h[cfg_addr] <= cfg_data;
                    end
                    if (cfg_we && !addr_ok) begin
                        cfg_err <= 1'b1;
                    end
                    rows_written <= rows_nx;
                    if (cfg_done) begin
                        if (&rows_nx) begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (cfg_we) begin
                        cfg_err <= 1'b1;
                    end
                    if (cfg_clear) begin
                        state   <= ST_DRAIN;
                        running <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (cfg_we) begin
                        cfg_err <= 1'b1;
                    end
                    if (!s1_valid && !out_valid) begin
                        state <= ST_CFG;
                    end
                end
                default: begin
                    state   <= ST_CFG;
                    running <= 1'b0;
                end
            endcase

            // Stage 1 refills whenever it is empty or its word moves on.
            if (s1_load) begin
                s1_valid <= in_fire;
                if (in_fire) begin
                    pp <= prod;
                end
            end
            if (s2_load) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= reduced;
                end
            end
        end
    end

endmodule

// File: tb/tb_bmf_h_decoder_seq.sv
// Bench for bmf_h_decoder_seq: OR and XOR instances share stimulus; a queue scoreboard per
// instance checks every emitted word in order.
module tb_bmf_h_decoder_seq;

    localparam int unsigned K  = 7;
    localparam int unsigned M  = 8;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [M-1:0]  cfg_data;
    logic          cfg_done;
    logic          cfg_clear;
    logic          in_valid;
    logic [K-1:0]  in_k;
    logic          out_ready;

    logic          cfg_err0, running0, in_ready0, out_valid0;
    logic [M-1:0]  out_data0;
    logic          cfg_err1, running1, in_ready1, out_valid1;
    logic [M-1:0]  out_data1;

    always #5 clk = ~clk;

    bmf_h_decoder_seq #(.K(K), .M(M), .SEMIRING(0)) dut0 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_done(cfg_done), .cfg_clear(cfg_clear), .cfg_err(cfg_err0), .running(running0),
        .in_valid(in_valid), .in_ready(in_ready0), .in_k(in_k), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0)
    );

    bmf_h_decoder_seq #(.K(K), .M(M), .SEMIRING(1)) dut1 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_done(cfg_done), .cfg_clear(cfg_clear), .cfg_err(cfg_err1), .running(running1),
        .in_valid(in_valid), .in_ready(in_ready1), .in_k(in_k), .out_valid(out_valid1),
        .out_ready(out_ready), .out_data(out_data1)
    );

    typedef struct packed {
        logic [K-1:0] k;
        logic [M-1:0] e_or;
        logic [M-1:0] e_xor;
    } vec_t;

    vec_t          vec_a [6];
    vec_t          vec_b [6];
    logic [M-1:0]  ha [K];
    logic [M-1:0]  hb [K];
    logic [M-1:0]  hm [K];
    logic [M-1:0]  q0 [$];
    logic [M-1:0]  q1 [$];
    logic [M-1:0]  exp_in0, exp_in1;
    logic [M-1:0]  stall_data0;
    logic          stall0;
    logic          last_in_fire;
    int            n_checks = 0;
    int            n_pass   = 0;
    int            cycles   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [M-1:0] model(input logic [K-1:0] k, input bit use_xor);
        logic [M-1:0] r = '0;
        for (int i = 0; i < int'(K); i++) begin
            if (k[i]) r = use_xor ? (r ^ hm[i]) : (r | hm[i]);
        end
        return r;
    endfunction

    // One clock: sample handshakes at the falling edge, then step past the rising edge.
    task automatic tick();
        @(negedge clk);
        last_in_fire = in_valid && in_ready0 && !rst;
        if (last_in_fire) begin
            q0.push_back(exp_in0);
            q1.push_back(exp_in1);
        end
        if (stall0) begin
            check("stall_valid", 32'(out_valid0), 32'(1));
            check("stall_hold", 32'(out_data0), 32'(stall_data0));
        end
        if (out_valid0 && out_ready && !rst) begin
            if (q0.size() == 0) check("unexpected_out0", 32'(1), 32'(0));
            else check("out_or", 32'(out_data0), 32'(q0.pop_front()));
        end
        if (out_valid1 && out_ready && !rst) begin
            if (q1.size() == 0) check("unexpected_out1", 32'(1), 32'(0));
            else check("out_xor", 32'(out_data1), 32'(q1.pop_front()));
        end
        stall0      = out_valid0 && !out_ready && !rst;
        stall_data0 = out_data0;
        @(posedge clk);
        #1;
        cycles++;
    endtask

    task automatic cfg_wr(input int a, input logic [M-1:0] d);
        cfg_we   = 1'b1;
        cfg_addr = AW'(a);
        cfg_data = d;
        if (a < int'(K)) hm[a] = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [K-1:0] k, input logic [M-1:0] e0, input logic [M-1:0] e1);
        int n = 0;
        in_valid = 1'b1;
        in_k     = k;
        exp_in0  = e0;
        exp_in1  = e1;
        do begin
            tick();
            n++;
        end while (!last_in_fire && n < 50);
        if (!last_in_fire) check("send_timeout", 32'(0), 32'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && (q0.size() != 0 || q1.size() != 0); i++) tick();
        check("drain_empty", 32'(q0.size() + q1.size()), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c0;
        int sent;
        ha = '{8'h02, 8'h05, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        hb = '{8'h01, 8'h01, 8'h3C, 8'hA5, 8'h0F, 8'hF0, 8'h81};
        vec_a[0] = '{7'h01, 8'h02, 8'h02};
        vec_a[1] = '{7'h02, 8'h05, 8'h05};
        vec_a[2] = '{7'h03, 8'h07, 8'h07};
        vec_a[3] = '{7'h04, 8'h08, 8'h08};
        vec_a[4] = '{7'h41, 8'h82, 8'h82};
        vec_a[5] = '{7'h7F, 8'hFF, 8'hFF};
        vec_b[0] = '{7'h03, 8'h01, 8'h00};
        vec_b[1] = '{7'h01, 8'h01, 8'h01};
        vec_b[2] = '{7'h0C, 8'hBD, 8'h99};
        vec_b[3] = '{7'h30, 8'hFF, 8'hFF};
        vec_b[4] = '{7'h07, 8'h3D, 8'h3C};
        vec_b[5] = '{7'h44, 8'hBD, 8'hBD};
        for (int i = 0; i < int'(K); i++) hm[i] = '0;

        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_done = 1'b0;
        cfg_clear = 1'b0; in_valid = 1'b0; in_k = '0; out_ready = 1'b1;
        exp_in0 = '0; exp_in1 = '0; stall0 = 1'b0; stall_data0 = '0; last_in_fire = 1'b0;
        tick();
        tick();
        check("rst_running", 32'(running0), 32'(0));
        check("rst_in_ready", 32'(in_ready0), 32'(0));
        check("rst_out_valid", 32'(out_valid0), 32'(0));
        check("rst_out_data", 32'(out_data0), 32'(0));
        check("rst_cfg_err", 32'(cfg_err0), 32'(0));
        rst = 1'b0;

        // Incomplete H must refuse to run.
        for (int i = 0; i < 6; i++) cfg_wr(i, ha[i]);
        cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
        check("partial_running", 32'(running0), 32'(0));
        check("partial_err", 32'(cfg_err0), 32'(1));
        check("partial_in_ready", 32'(in_ready0), 32'(0));

        // Last row written in the same cycle as cfg_done.
        cfg_we = 1'b1; cfg_addr = 3'd6; cfg_data = ha[6]; hm[6] = ha[6]; cfg_done = 1'b1;
        tick();
        cfg_we = 1'b0; cfg_done = 1'b0;
        check("run_running", 32'(running0), 32'(1));
        check("run_in_ready", 32'(in_ready0), 32'(1));

        // Two-cycle latency.
        in_valid = 1'b1; in_k = 7'h02; exp_in0 = 8'h05; exp_in1 = 8'h05;
        tick();
        in_valid = 1'b0;
        check("lat_accept", 32'(last_in_fire), 32'(1));
        check("lat_edge1_valid", 32'(out_valid0), 32'(0));
        tick();
        check("lat_edge2_valid", 32'(out_valid0), 32'(1));
        check("lat_edge2_data", 32'(out_data0), 32'(8'h05));
        drain();

        c0 = cycles;
        for (int i = 0; i < 6; i++) send(vec_a[i].k, vec_a[i].e_or, vec_a[i].e_xor);
        check("throughput", 32'(cycles - c0), 32'(6));
        drain();

        // Reload with a matrix where OR and XOR differ.
        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
        tick(); tick(); tick();
        for (int i = 0; i < int'(K); i++) cfg_wr(i, hb[i]);
        cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
        check("reload_running", 32'(running0), 32'(1));
        for (int i = 0; i < 6; i++) send(vec_b[i].k, vec_b[i].e_or, vec_b[i].e_xor);
        drain();

        // Streaming with out_ready pattern 1,0,0,1.
        sent = 0;
        for (int cyc = 0; cyc < 300 && (sent < 16 || q0.size() != 0); cyc++) begin
            in_valid  = (sent < 16);
            in_k      = K'(8 + sent);
            exp_in0   = model(in_k, 1'b0);
            exp_in1   = model(in_k, 1'b1);
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            tick();
            if (last_in_fire) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("stream_sent", 32'(sent), 32'(16));
        check("stream_empty", 32'(q0.size() + q1.size()), 32'(0));

        // cfg_clear with two words in flight.
        out_ready = 1'b0;
        in_valid = 1'b1; in_k = 7'h0C; exp_in0 = 8'hBD; exp_in1 = 8'h99;
        tick();
        in_k = 7'h30; exp_in0 = 8'hFF; exp_in1 = 8'hFF; cfg_clear = 1'b1;
        tick();
        check("clear_fire", 32'(last_in_fire), 32'(1));
        cfg_clear = 1'b0; in_k = 7'h01;
        check("clear_in_ready", 32'(in_ready0), 32'(0));
        check("clear_running", 32'(running0), 32'(0));
        tick();
        check("drain_no_accept", 32'(last_in_fire), 32'(0));
        in_valid = 1'b0; out_ready = 1'b1;
        drain();
        tick(); tick();
        cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
        check("redone_running", 32'(running0), 32'(1));
        send(7'h07, 8'h3D, 8'h3C);
        drain();

        // Reset with a full pipeline.
        out_ready = 1'b0; in_valid = 1'b1; in_k = 7'h44; exp_in0 = 8'hBD; exp_in1 = 8'hBD;
        for (int i = 0; i < 4; i++) tick();
        check("full_in_ready", 32'(in_ready0), 32'(0));
        rst = 1'b1;
        tick();
        check("mid_rst_out_valid", 32'(out_valid0), 32'(0));
        check("mid_rst_in_ready", 32'(in_ready0), 32'(0));
        check("mid_rst_running", 32'(running0), 32'(0));
        check("mid_rst_cfg_err", 32'(cfg_err0), 32'(0));
        check("mid_rst_out_valid1", 32'(out_valid1), 32'(0));
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        q0.delete(); q1.delete(); stall0 = 1'b0;

        cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
        check("post_rst_no_run", 32'(running0), 32'(0));
        check("post_rst_err", 32'(cfg_err0), 32'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
